// File: rtl/iter_div.sv
// ---------------------------------------------------------------------------
// iter_div -- iterative restoring divider, one quotient bit per clock.
//
// A request is taken in IDLE, the magnitudes are divided MSB first over
// WIDTH cycles in CALC, and FIX applies the truncating-division signs and
// publishes the results together with a one-cycle done pulse.
//
// Ports
//   clock        single rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        divide request, only looked at in IDLE
//   is_signed    1 = two's-complement operands, 0 = unsigned (taken with start)
//   dividend     numerator (taken with start)
//   divisor      denominator (taken with start)
//   busy         high in CALC and FIX
//   done         one-cycle pulse when quotient/remainder/div_by_zero update
//   quotient     registered quotient
//   remainder    registered remainder
//   div_by_zero  registered flag, set with the results of a zero-divisor request
//
// States
//   IDLE | waiting for start; results held
//   CALC | one shift-subtract step per cycle, WIDTH steps
//   FIX  | sign correction, results registered, done pulsed
// ---------------------------------------------------------------------------
module iter_div #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] abs_dividend;
  logic [WIDTH-1:0] abs_divisor;

  // Partial remainder shifted left by one with the next dividend bit brought in.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  // A set top bit means shifted >= 2^WIDTH, which always exceeds the divisor;
  // otherwise the subtraction borrow decides.
  assign ge      = shifted[WIDTH] | ~diff[WIDTH];

  assign abs_dividend = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign abs_divisor  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvs_d         = dvs_q;
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
    dbz_d         = dbz_q;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          neg_quo_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_rem_d = is_signed & dividend[WIDTH-1];
          if (divisor == '0) begin
            dbz_d   = 1'b1;
            quo_d   = '1;
            rem_d   = dividend;
            state_d = FIX;
          end else begin
            dbz_d   = 1'b0;
            quo_d   = abs_dividend;
            dvs_d   = abs_divisor;
            rem_d   = '0;
            cnt_d   = CW'(WIDTH);
            state_d = CALC;
          end
        end
      end

      CALC: begin
        rem_d = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ge};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        if (dbz_q) begin
          quotient_d    = quo_q;
          remainder_d   = rem_q;
          div_by_zero_d = 1'b1;
        end else begin
          quotient_d    = neg_quo_q ? -quo_q : quo_q;
          remainder_d   = neg_rem_q ? -rem_q : rem_q;
          div_by_zero_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      dbz_q         <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      dvs_q         <= dvs_d;
      neg_quo_q     <= neg_quo_d;
      neg_rem_q     <= neg_rem_d;
      dbz_q         <= dbz_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_iter_div.sv
// ---------------------------------------------------------------------------
// tb_iter_div -- self-checking bench for iter_div (WIDTH = 32).
// Expected results come from plain integer division on 64-bit values.
// ---------------------------------------------------------------------------
module tb_iter_div;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail = 0;

  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;
  logic         last_z = 1'b0;

  iter_div #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sa, sb, sq, sr;
    if (b == 0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      q  = sq[W-1:0];
      r  = sr[W-1:0];
      z  = 1'b0;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge that took start.
  task automatic launch(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b);
    is_signed = sg;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start     = 1'b0;
    // Scramble the inputs: the divider must work from its latched copies.
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = ~sg;
  endtask

  task automatic wait_done(input int poke_at, output int edges);
    bit busy_ok = 1'b1;
    bit hold_ok = 1'b1;
    bit excl_ok = 1'b1;
    edges = 0;
    if (!busy) busy_ok = 1'b0;
    while (edges < 200) begin
      @(posedge clock);
      #1;
      edges++;
      if (edges == poke_at) begin
        start    = 1'b1;
        dividend = $urandom;
        divisor  = $urandom | 32'h1;
      end else begin
        start = 1'b0;
      end
      if (done && busy) excl_ok = 1'b0;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      if (quotient !== last_q || remainder !== last_r || div_by_zero !== last_z) hold_ok = 1'b0;
    end
    start = 1'b0;
    if (!done) edges = -1;
    check("busy_while_running", W'(busy_ok), W'(1));
    check("done_busy_exclusive", W'(excl_ok), W'(1));
    check("outputs_held", W'(hold_ok), W'(1));
  endtask

  task automatic run(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b,
                     input string tag, input int poke_at);
    logic [W-1:0] eq, er;
    logic         ez;
    int           edges;
    model(sg, a, b, eq, er, ez);
    launch(sg, a, b);
    wait_done(poke_at, edges);
    check({tag, "_latency"}, W'(edges), ez ? W'(1) : W'(W + 1));
    check({tag, "_quotient"}, quotient, eq);
    check({tag, "_remainder"}, remainder, er);
    check({tag, "_div_by_zero"}, W'(div_by_zero), W'(ez));
    last_q = eq;
    last_r = er;
    last_z = ez;
  endtask

  initial begin
    int done_seen;
    bit sg;
    logic [W-1:0] a, b;

    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", W'(busy), '0);
    check("reset_done", W'(done), '0);
    check("reset_quotient", quotient, '0);
    check("reset_remainder", remainder, '0);
    check("reset_div_by_zero", W'(div_by_zero), '0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    run(1'b0, 32'd100, 32'd7, "u100_7", -1);
    @(posedge clock);
    #1;
    check("done_one_cycle", W'(done), '0);
    run(1'b1, 32'hFFFF_FFF9, 32'd2, "s_m7_2", -1);
    run(1'b1, 32'd7, 32'hFFFF_FFFE, "s_7_m2", -1);
    run(1'b0, 32'hFFFF_FFFF, 32'd1, "u_max_1", -1);
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "s_mn_m1", -1);
    run(1'b0, 32'd5, 32'd0, "u5_0", -1);
    run(1'b1, 32'd5, 32'd0, "s5_0", -1);
    run(1'b0, 32'd50, 32'd5, "clear_dbz", -1);

    // Ignored start mid-divide, then a start coincident with done.
    run(1'b0, 32'd12345, 32'd67, "busy_start", 10);
    run(1'b1, 32'hFFFF_FC18, 32'd33, "back_to_back", -1);

    // Reset in the middle of a divide.
    launch(1'b0, 32'd1000, 32'd3);
    repeat (14) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_busy", W'(busy), '0);
    check("abort_done", W'(done), '0);
    check("abort_quotient", quotient, '0);
    check("abort_remainder", remainder, '0);
    check("abort_div_by_zero", W'(div_by_zero), '0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    last_q = '0;
    last_r = '0;
    last_z = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done) done_seen++;
    end
    check("abort_no_done", W'(done_seen), '0);
    check("abort_idle", W'(busy), '0);
    run(1'b0, 32'd9, 32'd3, "after_abort", -1);

    for (int i = 0; i < 60; i++) begin
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = -W'($urandom_range(1, 15));
        3: begin
          a = 32'h8000_0000;
          b = 32'hFFFF_FFFF;
        end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run(sg, a, b, $sformatf("rand%0d", i), -1);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clock);
        #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
